// File: rtl/pwm_ctrl.sv
// PWM channel register block: shadow/active channel fields behind a one-outstanding request/response bus.
// Build option: define PWM_CTRL_AUTOCOMMIT_EN to make channel writes update the active copy directly.
module pwm_ctrl #(
  parameter int unsigned NCH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [6:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  pwm0_mode_o,
  output logic [31:0] pwm0_period_o,
  output logic [31:0] pwm0_threshold1_o,
  output logic [31:0] pwm0_threshold2_o,
  output logic [11:0] pwm0_step_o,
  output logic [1:0]  pwm1_mode_o,
  output logic [31:0] pwm1_period_o,
  output logic [31:0] pwm1_threshold1_o,
  output logic [31:0] pwm1_threshold2_o,
  output logic [11:0] pwm1_step_o
);

`ifdef PWM_CTRL_AUTOCOMMIT_EN
  localparam bit AUTOCOMMIT = 1'b1;
`else
  localparam bit AUTOCOMMIT = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_RESP} state_e;
  typedef enum logic [2:0] {F_MODE, F_PERIOD, F_THR1, F_THR2, F_STEP} field_e;

  state_e      state_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic [1:0]  sh_mode_q [NCH];
  logic [31:0] sh_per_q  [NCH];
  logic [31:0] sh_thr1_q [NCH];
  logic [31:0] sh_thr2_q [NCH];
  logic [11:0] sh_step_q [NCH];
  logic [1:0]  ac_mode_q [NCH];
  logic [31:0] ac_per_q  [NCH];
  logic [31:0] ac_thr1_q [NCH];
  logic [31:0] ac_thr2_q [NCH];
  logic [11:0] ac_step_q [NCH];

  logic        dec_ctrl, dec_ch, dec_err, dec_chn;
  field_e      dec_fld;
  logic        valid_ok, pending;
  logic [31:0] rd_data;
  logic        acc_err;
  logic [31:0] acc_rdata;
  logic        do_commit, do_kill;

  // Channel N occupies 0x20*(N+1); addr[6] selects the channel, addr[4:2] the field.
  always_comb begin
    dec_ctrl = 1'b0;
    dec_ch   = 1'b0;
    dec_err  = 1'b1;
    dec_chn  = req_addr_i[6];
    dec_fld  = F_MODE;
    if (req_addr_i[1:0] == 2'b00) begin
      if (req_addr_i == 7'h00) begin
        dec_ctrl = 1'b1;
        dec_err  = 1'b0;
      end else if (req_addr_i[6:5] == 2'b01 || req_addr_i[6:5] == 2'b10) begin
        dec_ch  = 1'b1;
        dec_err = 1'b0;
        case (req_addr_i[4:2])
          3'd0:    dec_fld = F_MODE;
          3'd1:    dec_fld = F_PERIOD;
          3'd2:    dec_fld = F_THR1;
          3'd3:    dec_fld = F_THR2;
          3'd4:    dec_fld = F_STEP;
          default: begin
            dec_ch  = 1'b0;
            dec_err = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    valid_ok = 1'b1;
    pending  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sh_mode_q[i] != 2'd0 &&
          (sh_per_q[i] == '0 || sh_thr1_q[i] > sh_per_q[i] ||
           (sh_mode_q[i] == 2'd2 && sh_thr1_q[i] > sh_thr2_q[i])))
        valid_ok = 1'b0;
      if (sh_mode_q[i] != ac_mode_q[i] || sh_per_q[i] != ac_per_q[i] ||
          sh_thr1_q[i] != ac_thr1_q[i] || sh_thr2_q[i] != ac_thr2_q[i] ||
          sh_step_q[i] != ac_step_q[i])
        pending = 1'b1;
    end
    if (AUTOCOMMIT)
      pending = 1'b0;
  end

  always_comb begin
    rd_data = '0;
    if (dec_ctrl) begin
      rd_data[1] = pending;
      for (int unsigned i = 0; i < NCH; i++)
        rd_data[2+i] = (ac_mode_q[i] != 2'd0);
    end else if (dec_ch) begin
      case (dec_fld)
        F_MODE:   rd_data = {30'd0, sh_mode_q[dec_chn]};
        F_PERIOD: rd_data = sh_per_q[dec_chn];
        F_THR1:   rd_data = sh_thr1_q[dec_chn];
        F_THR2:   rd_data = sh_thr2_q[dec_chn];
        F_STEP:   rd_data = {20'd0, sh_step_q[dec_chn]};
        default:  rd_data = '0;
      endcase
    end
  end

  // KILL outranks COMMIT and never fails; COMMIT fails only on validation.
  always_comb begin
    do_kill   = req_we_i && dec_ctrl && req_wdata_i[2];
    do_commit = req_we_i && dec_ctrl && req_wdata_i[0] && !req_wdata_i[2] && !AUTOCOMMIT;
    acc_err   = dec_err;
    if (do_commit && !valid_ok)
      acc_err = 1'b1;
    if (req_we_i && dec_ch && dec_fld == F_MODE && req_wdata_i[1:0] == 2'd3)
      acc_err = 1'b1;
    acc_rdata = (req_we_i || acc_err) ? '0 : rd_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        sh_mode_q[i] <= '0;
        sh_per_q[i]  <= '0;
        sh_thr1_q[i] <= '0;
        sh_thr2_q[i] <= '0;
        sh_step_q[i] <= '0;
        ac_mode_q[i] <= '0;
        ac_per_q[i]  <= '0;
        ac_thr1_q[i] <= '0;
        ac_thr2_q[i] <= '0;
        ac_step_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (req_valid_i && ready_q) begin
            state_q      <= S_RESP;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= acc_rdata;
            if (req_we_i && !acc_err) begin
              if (dec_ch) begin
                case (dec_fld)
                  F_MODE: begin
                    sh_mode_q[dec_chn] <= req_wdata_i[1:0];
                    if (AUTOCOMMIT) ac_mode_q[dec_chn] <= req_wdata_i[1:0];
                  end
                  F_PERIOD: begin
                    sh_per_q[dec_chn] <= req_wdata_i;
                    if (AUTOCOMMIT) ac_per_q[dec_chn] <= req_wdata_i;
                  end
                  F_THR1: begin
                    sh_thr1_q[dec_chn] <= req_wdata_i;
                    if (AUTOCOMMIT) ac_thr1_q[dec_chn] <= req_wdata_i;
                  end
                  F_THR2: begin
                    sh_thr2_q[dec_chn] <= req_wdata_i;
                    if (AUTOCOMMIT) ac_thr2_q[dec_chn] <= req_wdata_i;
                  end
                  F_STEP: begin
                    sh_step_q[dec_chn] <= req_wdata_i[11:0];
                    if (AUTOCOMMIT) ac_step_q[dec_chn] <= req_wdata_i[11:0];
                  end
                  default: ;
                endcase
              end
              if (do_kill) begin
                for (int unsigned i = 0; i < NCH; i++)
                  ac_mode_q[i] <= '0;
              end else if (do_commit) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                  ac_mode_q[i] <= sh_mode_q[i];
                  ac_per_q[i]  <= sh_per_q[i];
                  ac_thr1_q[i] <= sh_thr1_q[i];
                  ac_thr2_q[i] <= sh_thr2_q[i];
                  ac_step_q[i] <= sh_step_q[i];
                end
              end
            end
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o       = ready_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_err_o        = resp_err_q;
  assign resp_rdata_o      = resp_rdata_q;
  assign pwm0_mode_o       = ac_mode_q[0];
  assign pwm0_period_o     = ac_per_q[0];
  assign pwm0_threshold1_o = ac_thr1_q[0];
  assign pwm0_threshold2_o = ac_thr2_q[0];
  assign pwm0_step_o       = ac_step_q[0];
  assign pwm1_mode_o       = ac_mode_q[1];
  assign pwm1_period_o     = ac_per_q[1];
  assign pwm1_threshold1_o = ac_thr1_q[1];
  assign pwm1_threshold2_o = ac_thr2_q[1];
  assign pwm1_step_o       = ac_step_q[1];

endmodule

// File: doc/pwm_ctrl.md
PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2, number of PWM channels configured (fixed at 2 in this revision).
REQ-002 SHALL have port clk_i  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port req_valid_i  input  1  bus request valid.
REQ-005 SHALL have port req_ready_o  output  1  controller can accept a request.
REQ-006 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr_i  input  7  byte address, word aligned.
REQ-008 SHALL have port req_wdata_i  input  32  write data.
REQ-009 SHALL have port resp_valid_o  output  1  response valid.
REQ-010 SHALL have port resp_ready_i  input  1  response consumed.
REQ-011 SHALL have port resp_rdata_o  output  32  read data (0 on writes and errors).
REQ-012 SHALL have port resp_err_o  output  1  request rejected.
REQ-013 SHALL have ports pwmN_mode_o  output  2  active mode for channel N (N=0,1).
REQ-014 SHALL have ports pwmN_period_o, pwmN_threshold1_o, pwmN_threshold2_o  output  32  active values for channel N.
REQ-015 SHALL have ports pwmN_step_o  output  12  active step for channel N.

Function
REQ-016 SHALL decode: 0x00 CTRL; channel N block at 0x20+0x20*N: +0x0 MODE, +0x4 PERIOD, +0x8 THR1, +0xC THR2, +0x10 STEP; any other address, or addr[1:0]!=0, is an error.
REQ-017 SHALL keep a shadow and an active copy of every channel field; pwm*_o outputs SHALL be driven only from active registers.
REQ-018 SHALL implement FSM IDLE -> RESP: req_ready_o=1 only in IDLE; on req_valid_i&&req_ready_o perform the access and enter RESP next cycle.
REQ-019 SHALL hold resp_valid_o=1 with stable rdata/err in RESP until resp_ready_i=1, then return to IDLE (one request outstanding max; minimum two cycles per request).
REQ-020 SHALL return shadow values on channel-register reads, zero-extended (MODE 2 bits, STEP 12 bits).
REQ-021 SHALL reject (err=1, no state change) a MODE write with wdata[1:0]==3.
REQ-022 CTRL write bit0=1 (COMMIT) SHALL copy all shadow fields to active in the accept cycle's following edge, provided validation passes.
REQ-023 Validation SHALL fail if any channel has shadow mode!=0 and (period==0 or threshold1>period or (mode==2 and threshold1>threshold2)); on failure err=1 and active unchanged.
REQ-024 CTRL write bit2=1 (KILL) SHALL force all active modes to 0 regardless of validation; shadow unchanged; KILL with COMMIT SHALL give KILL priority.
REQ-025 CTRL read SHALL return bit0=0, bit1=1 if any shadow field differs from active (PENDING), bit2..bit3 = active mode nonzero for channel 0..1.
REQ-026 Bits of req_wdata_i beyond field width SHALL be ignored without error.
REQ-027 Requests presented during RESP SHALL be stalled (req_ready_o=0), not dropped.

Reset
REQ-028 SHALL, while rst_i=0, asynchronously clear all shadow and active registers, drive all pwm*_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, req_ready_o=0, FSM=IDLE.
REQ-029 SHALL assert req_ready_o in the first cycle after rst_i deasserts; reset mid-response SHALL discard the response.

Configuration
REQ-030 With PWM_CTRL_AUTOCOMMIT_EN defined, every successful channel-register write SHALL also update that active field on the same edge (validation skipped, COMMIT a no-op returning err=0, PENDING always 0); without it, active fields SHALL change only via COMMIT, KILL or reset.

Verification
REQ-031 Write ch0 PERIOD=100, THR1=25, MODE=1, then read pwm0_mode_o -> still 0; CTRL=0x1 -> next cycle pwm0_period_o=100, pwm0_threshold1_o=25, pwm0_mode_o=1, err=0.
REQ-032 ch1 MODE=2, PERIOD=100, THR1=60, THR2=40, COMMIT -> err=1, pwm1_* unchanged, CTRL read bit1=1.
REQ-033 Write MODE=3 to 0x40 -> err=1, read 0x40 returns previous value; read 0x14 -> err=1, rdata=0.
REQ-034 Hold resp_ready_i=0 for 5 cycles with second req_valid_i pending -> resp_valid_o stable, req_ready_o=0 throughout, second request accepted after release.
REQ-035 Both channels active, CTRL=0x5 -> both pwm*_mode_o=0 next cycle, err=0; rst_i=0 mid-RESP -> resp_valid_o=0 immediately.
